// File: rtl/cache_arbiter_if.sv
// Bundle of the icache/dcache miss ports and the physical-memory port seen by cache_arbiter.
// slave is the arbiter's view; master is the view of the caches plus main memory.
interface cache_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 256
);
   logic                  i_pmem_read;
   logic [ADDR_WIDTH-1:0] i_pmem_address;
   logic [LINE_WIDTH-1:0] i_pmem_rdata;
   logic                  i_pmem_resp;

   logic                  d_pmem_read;
   logic                  d_pmem_write;
   logic [ADDR_WIDTH-1:0] d_pmem_address;
   logic [LINE_WIDTH-1:0] d_pmem_wdata;
   logic [LINE_WIDTH-1:0] d_pmem_rdata;
   logic                  d_pmem_resp;

   logic                  mem_read;
   logic                  mem_write;
   logic [ADDR_WIDTH-1:0] mem_address;
   logic [LINE_WIDTH-1:0] mem_wdata;
   logic [LINE_WIDTH-1:0] mem_rdata;
   logic                  mem_resp;

   logic                  arb_busy;

   modport slave (
      input  i_pmem_read, i_pmem_address,
      input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
      input  mem_rdata, mem_resp,
      output i_pmem_rdata, i_pmem_resp,
      output d_pmem_rdata, d_pmem_resp,
      output mem_read, mem_write, mem_address, mem_wdata,
      output arb_busy
   );

   modport master (
      output i_pmem_read, i_pmem_address,
      output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
      output mem_rdata, mem_resp,
      input  i_pmem_rdata, i_pmem_resp,
      input  d_pmem_rdata, d_pmem_resp,
      input  mem_read, mem_write, mem_address, mem_wdata,
      input  arb_busy
   );
endinterface

// File: rtl/cache_arbiter.sv
// Shares one physical-memory port between icache and dcache, one latched line transaction
// at a time, alternating grants when both miss together.
module cache_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 256
) (
   input  logic            clk,
   input  logic            rst,
   cache_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
   typedef enum logic {GRANT_I, GRANT_D} grant_t;
   typedef enum logic {OP_READ, OP_WRITE} op_t;

   state_t                state_q, state_d;
   grant_t                last_grant_q, last_grant_d;
   op_t                   op_q, op_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LINE_WIDTH-1:0] wdata_q, wdata_d;

   logic i_req, d_req;

   assign i_req = bus.i_pmem_read;
   assign d_req = bus.d_pmem_read | bus.d_pmem_write;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= GRANT_I;
         op_q         <= OP_READ;
         addr_q       <= '0;
         wdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         op_q         <= op_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      last_grant_d     = last_grant_q;
      op_d             = op_q;
      addr_d           = addr_q;
      wdata_d          = wdata_q;
      bus.mem_read     = 1'b0;
      bus.mem_write    = 1'b0;
      bus.i_pmem_resp  = 1'b0;
      bus.d_pmem_resp  = 1'b0;
      bus.i_pmem_rdata = '0;
      bus.d_pmem_rdata = '0;

      unique case (state_q)
         IDLE: begin
            // On a tie the icache wins only if the dcache had the previous grant.
            if (i_req && (!d_req || last_grant_q == GRANT_D)) begin
               state_d      = SERVE_I;
               last_grant_d = GRANT_I;
               addr_d       = bus.i_pmem_address;
            end else if (d_req) begin
               state_d      = SERVE_D;
               last_grant_d = GRANT_D;
               addr_d       = bus.d_pmem_address;
               wdata_d      = bus.d_pmem_wdata;
               op_d         = bus.d_pmem_write ? OP_WRITE : OP_READ;
            end
         end
         SERVE_I: begin
            bus.mem_read = 1'b1;
            if (bus.mem_resp) begin
               bus.i_pmem_resp  = 1'b1;
               bus.i_pmem_rdata = bus.mem_rdata;
               state_d          = IDLE;
            end
         end
         SERVE_D: begin
            bus.mem_read  = (op_q == OP_READ);
            bus.mem_write = (op_q == OP_WRITE);
            if (bus.mem_resp) begin
               bus.d_pmem_resp  = 1'b1;
               bus.d_pmem_rdata = bus.mem_rdata;
               state_d          = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.mem_address = addr_q;
   assign bus.mem_wdata   = wdata_q;
   assign bus.arb_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: lone requests, ties, alternation, latching, async reset.
module tb_cache_arbiter;

   localparam int AW = 32;
   localparam int LW = 256;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   logic [LW-1:0] DAT_A5  = {32{8'hA5}};
   logic [LW-1:0] DAT_W1  = {8{32'h12345678}};
   logic [LW-1:0] DAT_W2  = {8{32'hDEADBEEF}};
   logic [LW-1:0] DAT_C3  = {32{8'hC3}};
   logic [LW-1:0] DAT_5A  = {32{8'h5A}};
   logic [LW-1:0] DAT_JNK = {16{16'hF00D}};

   cache_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

   cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      tests++;
      if ({bus.mem_read, bus.mem_write, bus.i_pmem_resp, bus.d_pmem_resp, bus.arb_busy} !== 5'b0) begin
         fails++;
         $display("FAIL reset_ctrl: got %b want 00000", {bus.mem_read, bus.mem_write, bus.i_pmem_resp, bus.d_pmem_resp, bus.arb_busy});
      end
      tests++;
      if (bus.mem_address !== '0 || bus.mem_wdata !== '0) begin
         fails++;
         $display("FAIL reset_bus: addr %h wdata %h want 0", bus.mem_address, bus.mem_wdata);
      end
      tick();
      rst = 1'b0;
   endtask

   task automatic test_lone_iread();
      tick();
      bus.i_pmem_read    = 1'b1;
      bus.i_pmem_address = 32'h0000_0040;
      @(negedge clk);
      tests++;
      if (bus.mem_read !== 1'b0) begin
         fails++;
         $display("FAIL iread_no_early_strobe: mem_read %b want 0", bus.mem_read);
      end
      tick();
      bus.mem_rdata = DAT_JNK;
      @(negedge clk);
      tests++;
      if (bus.mem_read !== 1'b1 || bus.mem_address !== 32'h40 || bus.arb_busy !== 1'b1) begin
         fails++;
         $display("FAIL iread_strobe: read %b addr %h busy %b want 1 00000040 1", bus.mem_read, bus.mem_address, bus.arb_busy);
      end
      tests++;
      if (bus.i_pmem_resp !== 1'b0 || bus.i_pmem_rdata !== '0) begin
         fails++;
         $display("FAIL iread_no_resp_yet: resp %b rdata %h want 0", bus.i_pmem_resp, bus.i_pmem_rdata);
      end
      tick();
      tick();
      bus.mem_resp  = 1'b1;
      bus.mem_rdata = DAT_A5;
      @(negedge clk);
      tests++;
      if (bus.i_pmem_resp !== 1'b1 || bus.i_pmem_rdata !== DAT_A5) begin
         fails++;
         $display("FAIL iread_resp: resp %b rdata %h want 1 %h", bus.i_pmem_resp, bus.i_pmem_rdata, DAT_A5);
      end
      tests++;
      if (bus.d_pmem_resp !== 1'b0 || bus.d_pmem_rdata !== '0) begin
         fails++;
         $display("FAIL iread_d_quiet: d_resp %b d_rdata %h want 0", bus.d_pmem_resp, bus.d_pmem_rdata);
      end
      tick();
      bus.mem_resp    = 1'b0;
      bus.i_pmem_read = 1'b0;
      @(negedge clk);
      tests++;
      if (bus.arb_busy !== 1'b0 || bus.mem_read !== 1'b0 || bus.i_pmem_resp !== 1'b0 || bus.mem_address !== 32'h40) begin
         fails++;
         $display("FAIL iread_back_idle: busy %b read %b resp %b addr %h want 0 0 0 00000040", bus.arb_busy, bus.mem_read, bus.i_pmem_resp, bus.mem_address);
      end
   endtask

   task automatic test_lone_dwrite();
      tick();
      bus.d_pmem_write   = 1'b1;
      bus.d_pmem_address = 32'h0000_1000;
      bus.d_pmem_wdata   = DAT_W1;
      tick();
      @(negedge clk);
      tests++;
      if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0 || bus.mem_address !== 32'h1000 || bus.mem_wdata !== DAT_W1) begin
         fails++;
         $display("FAIL dwrite_strobe: wr %b rd %b addr %h wdata %h want 1 0 00001000 %h", bus.mem_write, bus.mem_read, bus.mem_address, bus.mem_wdata, DAT_W1);
      end
      tick();
      bus.mem_resp = 1'b1;
      @(negedge clk);
      tests++;
      if (bus.d_pmem_resp !== 1'b1 || bus.i_pmem_resp !== 1'b0 || bus.mem_write !== 1'b1 || bus.mem_wdata !== DAT_W1) begin
         fails++;
         $display("FAIL dwrite_resp: d_resp %b i_resp %b wr %b wdata %h want 1 0 1 %h", bus.d_pmem_resp, bus.i_pmem_resp, bus.mem_write, bus.mem_wdata, DAT_W1);
      end
      tick();
      bus.mem_resp     = 1'b0;
      bus.d_pmem_write = 1'b0;
      @(negedge clk);
      tests++;
      if (bus.mem_write !== 1'b0 || bus.arb_busy !== 1'b0) begin
         fails++;
         $display("FAIL dwrite_back_idle: wr %b busy %b want 0 0", bus.mem_write, bus.arb_busy);
      end
   endtask

   task automatic test_simultaneous();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      bus.i_pmem_read    = 1'b1;
      bus.i_pmem_address = 32'h40;
      bus.d_pmem_read    = 1'b1;
      bus.d_pmem_address = 32'h80;
      tick();
      bus.mem_resp  = 1'b1;
      bus.mem_rdata = DAT_C3;
      @(negedge clk);
      tests++;
      if (bus.mem_read !== 1'b1 || bus.mem_address !== 32'h80 || bus.d_pmem_resp !== 1'b1 || bus.i_pmem_resp !== 1'b0) begin
         fails++;
         $display("FAIL sim_first_d: rd %b addr %h d_resp %b i_resp %b want 1 00000080 1 0", bus.mem_read, bus.mem_address, bus.d_pmem_resp, bus.i_pmem_resp);
      end
      tests++;
      if (bus.d_pmem_rdata !== DAT_C3 || bus.i_pmem_rdata !== '0) begin
         fails++;
         $display("FAIL sim_d_rdata: d %h i %h want %h 0", bus.d_pmem_rdata, bus.i_pmem_rdata, DAT_C3);
      end
      tick();
      bus.d_pmem_read = 1'b0;
      bus.mem_resp    = 1'b0;
      @(negedge clk);
      tests++;
      if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0 || bus.arb_busy !== 1'b0) begin
         fails++;
         $display("FAIL sim_gap: rd %b wr %b busy %b want 0 0 0", bus.mem_read, bus.mem_write, bus.arb_busy);
      end
      tick();
      bus.mem_resp  = 1'b1;
      bus.mem_rdata = DAT_5A;
      @(negedge clk);
      tests++;
      if (bus.mem_address !== 32'h40 || bus.i_pmem_resp !== 1'b1 || bus.i_pmem_rdata !== DAT_5A || bus.d_pmem_resp !== 1'b0) begin
         fails++;
         $display("FAIL sim_then_i: addr %h i_resp %b i_rdata %h d_resp %b want 00000040 1 %h 0", bus.mem_address, bus.i_pmem_resp, bus.i_pmem_rdata, bus.d_pmem_resp, DAT_5A);
      end
      tick();
      bus.i_pmem_read = 1'b0;
      bus.mem_resp    = 1'b0;
      @(negedge clk);
      tests++;
      if (bus.arb_busy !== 1'b0) begin
         fails++;
         $display("FAIL sim_end_idle: busy %b want 0", bus.arb_busy);
      end
   endtask

   // Both caches re-request right after each resp; grants must alternate starting with D.
   task automatic test_contention();
      logic exp_d [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      int   n = 0;
      bit   i_hit = 0, d_hit = 0, i_low = 0, d_low = 0, prev_resp = 0;
      tick();
      bus.i_pmem_read    = 1'b1;
      bus.d_pmem_read    = 1'b1;
      bus.i_pmem_address = 32'h40;
      bus.d_pmem_address = 32'h80;
      bus.mem_resp       = 1'b1;
      bus.mem_rdata      = DAT_A5;
      for (int c = 0; c < 40 && n < 6; c++) begin
         @(negedge clk);
         if (prev_resp) begin
            tests++;
            if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin
               fails++;
               $display("FAIL contention_gap: rd %b wr %b want 0 0 (after grant %0d)", bus.mem_read, bus.mem_write, n);
            end
         end
         i_hit     = bus.i_pmem_resp;
         d_hit     = bus.d_pmem_resp;
         prev_resp = i_hit | d_hit;
         if (prev_resp) begin
            tests++;
            if ((i_hit & d_hit) || d_hit !== exp_d[n]) begin
               fails++;
               $display("FAIL contention_grant%0d: d_resp %b i_resp %b want d_resp %b", n, d_hit, i_hit, exp_d[n]);
            end
            n++;
         end
         tick();
         if (i_hit) begin bus.i_pmem_read = 1'b0; i_low = 1; end
         else if (i_low) begin bus.i_pmem_read = 1'b1; i_low = 0; end
         if (d_hit) begin bus.d_pmem_read = 1'b0; d_low = 1; end
         else if (d_low) begin bus.d_pmem_read = 1'b1; d_low = 0; end
      end
      bus.i_pmem_read = 1'b0;
      bus.d_pmem_read = 1'b0;
      bus.mem_resp    = 1'b0;
      tests++;
      if (n != 6) begin
         fails++;
         $display("FAIL contention_count: got %0d grants want 6", n);
      end
      tick();
      @(negedge clk);
      tests++;
      if (bus.arb_busy !== 1'b0) begin
         fails++;
         $display("FAIL contention_idle: busy %b want 0", bus.arb_busy);
      end
   endtask

   task automatic test_mid_change();
      tick();
      bus.d_pmem_read    = 1'b1;
      bus.d_pmem_write   = 1'b1;
      bus.d_pmem_address = 32'h2000;
      bus.d_pmem_wdata   = DAT_W1;
      tick();
      bus.d_pmem_address = 32'h3000;
      bus.d_pmem_wdata   = DAT_W2;
      bus.d_pmem_write   = 1'b0;
      @(negedge clk);
      tests++;
      if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0) begin
         fails++;
         $display("FAIL mid_write_wins: wr %b rd %b want 1 0", bus.mem_write, bus.mem_read);
      end
      tests++;
      if (bus.mem_address !== 32'h2000 || bus.mem_wdata !== DAT_W1) begin
         fails++;
         $display("FAIL mid_latched: addr %h wdata %h want 00002000 %h", bus.mem_address, bus.mem_wdata, DAT_W1);
      end
      tick();
      bus.mem_resp  = 1'b1;
      bus.mem_rdata = DAT_C3;
      @(negedge clk);
      tests++;
      if (bus.d_pmem_resp !== 1'b1 || bus.mem_address !== 32'h2000 || bus.mem_wdata !== DAT_W1 || bus.mem_write !== 1'b1) begin
         fails++;
         $display("FAIL mid_resp: d_resp %b addr %h wr %b wdata %h want 1 00002000 1 %h", bus.d_pmem_resp, bus.mem_address, bus.mem_write, bus.mem_wdata, DAT_W1);
      end
      tick();
      bus.mem_resp    = 1'b0;
      bus.d_pmem_read = 1'b0;
      @(negedge clk);
      tests++;
      if (bus.arb_busy !== 1'b0) begin
         fails++;
         $display("FAIL mid_back_idle: busy %b want 0", bus.arb_busy);
      end
   endtask

   task automatic test_reset_mid();
      tick();
      bus.i_pmem_read    = 1'b1;
      bus.i_pmem_address = 32'h500;
      tick();
      #1;
      tests++;
      if (bus.mem_read !== 1'b1 || bus.mem_address !== 32'h500) begin
         fails++;
         $display("FAIL rstmid_serving: rd %b addr %h want 1 00000500", bus.mem_read, bus.mem_address);
      end
      bus.mem_resp  = 1'b1;
      bus.mem_rdata = DAT_A5;
      #1;
      rst = 1'b1;
      #1;
      tests++;
      if ({bus.mem_read, bus.mem_write, bus.i_pmem_resp, bus.d_pmem_resp, bus.arb_busy} !== 5'b0) begin
         fails++;
         $display("FAIL rstmid_ctrl: got %b want 00000", {bus.mem_read, bus.mem_write, bus.i_pmem_resp, bus.d_pmem_resp, bus.arb_busy});
      end
      tests++;
      if (bus.mem_address !== '0 || bus.mem_wdata !== '0 || bus.i_pmem_rdata !== '0 || bus.d_pmem_rdata !== '0) begin
         fails++;
         $display("FAIL rstmid_data: addr %h wdata %h i_rdata %h d_rdata %h want 0", bus.mem_address, bus.mem_wdata, bus.i_pmem_rdata, bus.d_pmem_rdata);
      end
      bus.i_pmem_read = 1'b0;
      bus.mem_resp    = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      bus.i_pmem_read    = 1'b1;
      bus.i_pmem_address = 32'h40;
      bus.d_pmem_read    = 1'b1;
      bus.d_pmem_address = 32'h80;
      @(negedge clk);
      tests++;
      if (bus.arb_busy !== 1'b0 || bus.mem_read !== 1'b0) begin
         fails++;
         $display("FAIL rstmid_idle: busy %b rd %b want 0 0", bus.arb_busy, bus.mem_read);
      end
      tick();
      bus.mem_resp = 1'b1;
      @(negedge clk);
      tests++;
      if (bus.mem_address !== 32'h80 || bus.d_pmem_resp !== 1'b1 || bus.i_pmem_resp !== 1'b0) begin
         fails++;
         $display("FAIL rstmid_tie_d: addr %h d_resp %b i_resp %b want 00000080 1 0", bus.mem_address, bus.d_pmem_resp, bus.i_pmem_resp);
      end
      tick();
      bus.mem_resp    = 1'b0;
      bus.i_pmem_read = 1'b0;
      bus.d_pmem_read = 1'b0;
      @(negedge clk);
      tests++;
      if (bus.arb_busy !== 1'b0) begin
         fails++;
         $display("FAIL rstmid_end_idle: busy %b want 0", bus.arb_busy);
      end
   endtask

   initial begin
      bus.i_pmem_read    = 1'b0;
      bus.i_pmem_address = '0;
      bus.d_pmem_read    = 1'b0;
      bus.d_pmem_write   = 1'b0;
      bus.d_pmem_address = '0;
      bus.d_pmem_wdata   = '0;
      bus.mem_rdata      = '0;
      bus.mem_resp       = 1'b0;
      test_reset();
      test_lone_iread();
      test_lone_dwrite();
      test_simultaneous();
      test_contention();
      test_mid_change();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
